// File: rtl/lcd_pkg.sv
// Shared constants and types for the 8080-style LCD bus receiver.
// Command codes, pixel width and the receive-mode encoding.
package lcd_pkg;

  localparam logic [7:0] CMD_CASET  = 8'h2A;
  localparam logic [7:0] CMD_PASET  = 8'h2B;
  localparam logic [7:0] CMD_RAMWR  = 8'h2C;
  localparam logic [7:0] CMD_RAMWRC = 8'h3C;

  localparam int RGB565_W = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PARAM    = 2'd1,
    PIX_NEW  = 2'd2,
    PIX_CONT = 2'd3
  } mode_e;

  // Parameter index counter; holds at 15 once reached.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/lcd_sync.sv
// Multi-flop synchroniser chain for a bundle of bus signals.
// RST_VAL sets the idle value the chain holds while reset is applied.
module lcd_sync #(
  parameter int             W       = 1,
  parameter int             STAGES  = 2,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [STAGES-1:0][W-1:0] pipe_q, pipe_d;

  always_comb begin
    pipe_d = {pipe_q[STAGES-2:0], i_d};
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) pipe_q <= {STAGES{RST_VAL}};
    else          pipe_q <= pipe_d;
  end

  assign o_q = pipe_q[STAGES-1];

endmodule

// File: rtl/lcd_bus_rx.sv
// 8080-style LCD write receiver: decodes commands/parameters, tracks the
// 2Ah/2Bh address window and emits coordinate-tagged RGB565 pixels.
module lcd_bus_rx
  import lcd_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2,
  parameter int X_W         = 10,
  parameter int Y_W         = 10
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_lcd_wr,
  input  logic                i_lcd_rs,
  input  logic                i_lcd_cs_n,
  input  logic                i_lcd_rst_n,
  input  logic [DATA_W-1:0]   i_lcd_data,
  output logic [7:0]          o_command,
  output logic                o_command_valid,
  output logic [7:0]          o_param,
  output logic [3:0]          o_param_idx,
  output logic                o_param_valid,
  output logic [X_W-1:0]      o_win_x0,
  output logic [X_W-1:0]      o_win_x1,
  output logic [Y_W-1:0]      o_win_y0,
  output logic [Y_W-1:0]      o_win_y1,
  output logic [RGB565_W-1:0] o_pix_rgb565,
  output logic [X_W-1:0]      o_pix_x,
  output logic [Y_W-1:0]      o_pix_y,
  output logic                o_pix_valid,
  output logic                o_frame_start
);

  // ---------------------------------------------------------------- sync
  logic [3:0]        ctrl_s;
  logic [DATA_W-1:0] data_s;
  logic              wr_s, rs_s, cs_n_s, lrst_n_s;

  lcd_sync #(.W(4), .STAGES(SYNC_STAGES), .RST_VAL(4'b1100)) u_sync_ctrl (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     ({i_lcd_rst_n, i_lcd_cs_n, i_lcd_rs, i_lcd_wr}),
    .o_q     (ctrl_s)
  );

  lcd_sync #(.W(DATA_W), .STAGES(SYNC_STAGES), .RST_VAL('0)) u_sync_data (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_lcd_data),
    .o_q     (data_s)
  );

  assign {lrst_n_s, cs_n_s, rs_s, wr_s} = ctrl_s;

  // Panel reset from the MCU clears the same state as the system reset.
  logic core_rst;
  assign core_rst = !i_rst_n || !lrst_n_s;

  // ---------------------------------------------------------------- state
  logic                wr_prev_q,  wr_prev_d;
  logic                cs_prev_q,  cs_prev_d;
  mode_e               mode_q,     mode_d;
  logic [3:0]          idx_q,      idx_d;
  logic                phase_q,    phase_d;
  logic [7:0]          hi_q,       hi_d;
  logic [23:0]         wbuf_q,     wbuf_d;
  logic                armed_q,    armed_d;
  logic [X_W-1:0]      cur_x_q,    cur_x_d;
  logic [Y_W-1:0]      cur_y_q,    cur_y_d;
  logic [X_W-1:0]      win_x0_q,   win_x0_d, win_x1_q, win_x1_d;
  logic [Y_W-1:0]      win_y0_q,   win_y0_d, win_y1_q, win_y1_d;
  logic [7:0]          command_q,  command_d;
  logic                cmd_vld_q,  cmd_vld_d;
  logic [7:0]          param_q,    param_d;
  logic [3:0]          param_idx_q, param_idx_d;
  logic                param_vld_q, param_vld_d;
  logic [RGB565_W-1:0] pix_rgb_q,  pix_rgb_d;
  logic [X_W-1:0]      pix_x_q,    pix_x_d;
  logic [Y_W-1:0]      pix_y_q,    pix_y_d;
  logic                pix_vld_q,  pix_vld_d;
  logic                fstart_q,   fstart_d;

  logic                strobe, cs_rise, pix_done;
  logic [7:0]          byte_in;
  logic [RGB565_W-1:0] data_ext, pix_val;
  logic [15:0]         lo_v, hi_v;

  assign strobe   = wr_s && !wr_prev_q && !cs_prev_q;
  assign cs_rise  = cs_n_s && !cs_prev_q;
  assign byte_in  = data_s[7:0];
  assign data_ext = RGB565_W'(data_s);
  assign lo_v     = {wbuf_q[23:16], wbuf_q[15:8]};
  assign hi_v     = {wbuf_q[7:0], byte_in};

  always_comb begin
    wr_prev_d   = wr_s;
    cs_prev_d   = cs_n_s;
    mode_d      = mode_q;
    idx_d       = idx_q;
    phase_d     = phase_q;
    hi_d        = hi_q;
    wbuf_d      = wbuf_q;
    armed_d     = armed_q;
    cur_x_d     = cur_x_q;
    cur_y_d     = cur_y_q;
    win_x0_d    = win_x0_q;
    win_x1_d    = win_x1_q;
    win_y0_d    = win_y0_q;
    win_y1_d    = win_y1_q;
    command_d   = command_q;
    cmd_vld_d   = 1'b0;
    param_d     = param_q;
    param_idx_d = param_idx_q;
    param_vld_d = 1'b0;
    pix_rgb_d   = pix_rgb_q;
    pix_x_d     = pix_x_q;
    pix_y_d     = pix_y_q;
    pix_vld_d   = 1'b0;
    fstart_d    = 1'b0;
    pix_done    = 1'b0;
    pix_val     = data_ext;

    if (strobe) begin
      if (!rs_s) begin
        command_d = byte_in;
        cmd_vld_d = 1'b1;
        idx_d     = 4'd0;
        phase_d   = 1'b0;
        case (byte_in)
          CMD_RAMWR: begin
            mode_d  = PIX_NEW;
            cur_x_d = win_x0_q;
            cur_y_d = win_y0_q;
            armed_d = 1'b1;
          end
          CMD_RAMWRC: mode_d = PIX_CONT;
          default:    mode_d = PARAM;
        endcase
      end else if (mode_q == IDLE || mode_q == PARAM) begin
        param_d     = byte_in;
        param_idx_d = idx_q;
        param_vld_d = 1'b1;
        idx_d       = sat_inc4(idx_q);
        if (command_q == CMD_CASET || command_q == CMD_PASET) begin
          case (idx_q)
            4'd0: wbuf_d[23:16] = byte_in;
            4'd1: wbuf_d[15:8]  = byte_in;
            4'd2: wbuf_d[7:0]   = byte_in;
            4'd3: begin
              if (command_q == CMD_CASET) begin
                win_x0_d = lo_v[X_W-1:0];
                win_x1_d = hi_v[X_W-1:0];
              end else begin
                win_y0_d = lo_v[Y_W-1:0];
                win_y1_d = hi_v[Y_W-1:0];
              end
            end
            default: ;
          endcase
        end
      end else if (DATA_W == 16) begin
        pix_done = 1'b1;
      end else if (!phase_q) begin
        hi_d    = byte_in;
        phase_d = 1'b1;
      end else begin
        pix_val  = {hi_q, byte_in};
        pix_done = 1'b1;
        phase_d  = 1'b0;
      end
    end

    if (pix_done) begin
      pix_rgb_d = pix_val;
      pix_x_d   = cur_x_q;
      pix_y_d   = cur_y_q;
      pix_vld_d = 1'b1;
      fstart_d  = armed_q;
      armed_d   = 1'b0;
      // x advances modulo 2^X_W so an inverted window still reaches x1.
      if (cur_x_q == win_x1_q) begin
        cur_x_d = win_x0_q;
        cur_y_d = (cur_y_q == win_y1_q) ? win_y0_q : cur_y_q + 1'b1;
      end else begin
        cur_x_d = cur_x_q + 1'b1;
      end
    end

    // Deselect drops any half-assembled pixel.
    if (cs_rise) phase_d = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (core_rst) begin
      wr_prev_q   <= 1'b0;
      cs_prev_q   <= 1'b1;
      mode_q      <= IDLE;
      idx_q       <= '0;
      phase_q     <= 1'b0;
      hi_q        <= '0;
      wbuf_q      <= '0;
      armed_q     <= 1'b0;
      cur_x_q     <= '0;
      cur_y_q     <= '0;
      win_x0_q    <= '0;
      win_x1_q    <= '1;
      win_y0_q    <= '0;
      win_y1_q    <= '1;
      command_q   <= '0;
      cmd_vld_q   <= 1'b0;
      param_q     <= '0;
      param_idx_q <= '0;
      param_vld_q <= 1'b0;
      pix_rgb_q   <= '0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      pix_vld_q   <= 1'b0;
      fstart_q    <= 1'b0;
    end else begin
      wr_prev_q   <= wr_prev_d;
      cs_prev_q   <= cs_prev_d;
      mode_q      <= mode_d;
      idx_q       <= idx_d;
      phase_q     <= phase_d;
      hi_q        <= hi_d;
      wbuf_q      <= wbuf_d;
      armed_q     <= armed_d;
      cur_x_q     <= cur_x_d;
      cur_y_q     <= cur_y_d;
      win_x0_q    <= win_x0_d;
      win_x1_q    <= win_x1_d;
      win_y0_q    <= win_y0_d;
      win_y1_q    <= win_y1_d;
      command_q   <= command_d;
      cmd_vld_q   <= cmd_vld_d;
      param_q     <= param_d;
      param_idx_q <= param_idx_d;
      param_vld_q <= param_vld_d;
      pix_rgb_q   <= pix_rgb_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      pix_vld_q   <= pix_vld_d;
      fstart_q    <= fstart_d;
    end
  end

  assign o_command       = command_q;
  assign o_command_valid = cmd_vld_q;
  assign o_param         = param_q;
  assign o_param_idx     = param_idx_q;
  assign o_param_valid   = param_vld_q;
  assign o_win_x0        = win_x0_q;
  assign o_win_x1        = win_x1_q;
  assign o_win_y0        = win_y0_q;
  assign o_win_y1        = win_y1_q;
  assign o_pix_rgb565    = pix_rgb_q;
  assign o_pix_x         = pix_x_q;
  assign o_pix_y         = pix_y_q;
  assign o_pix_valid     = pix_vld_q;
  assign o_frame_start   = fstart_q;

endmodule

// File: tb/tb_lcd_bus_rx.sv
// Directed bench for lcd_bus_rx: a 16-bit and an 8-bit instance share the
// bus lines and are selected by separate chip selects.
module tb_lcd_bus_rx;

  localparam int SYNC = 2;

  typedef struct packed {
    logic [15:0] rgb;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        fs;
  } pix_t;

  typedef struct packed {
    logic [7:0] val;
    logic [3:0] idx;
  } par_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lcd_wr = 1'b0, lcd_rs = 1'b0, lcd_rst_n = 1'b1;
  logic        cs16_n = 1'b1, cs8_n = 1'b1;
  logic [15:0] data = '0;
  int          cyc = 0;
  int          t_wr = 0;
  int          total = 0, bad = 0;

  logic [7:0]  cmd16, par16, cmd8, par8;
  logic [3:0]  pidx16, pidx8;
  logic        cv16, pv16, xv16, fs16, cv8, pv8, xv8, fs8;
  logic [9:0]  wx0_16, wx1_16, wy0_16, wy1_16, px16, py16;
  logic [9:0]  wx0_8, wx1_8, wy0_8, wy1_8, px8, py8;
  logic [15:0] rgb16, rgb8;

  pix_t pq16[$], pq8[$];
  par_t aq16[$], aq8[$];
  int   cq16[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lcd_bus_rx #(.DATA_W(16), .SYNC_STAGES(SYNC), .X_W(10), .Y_W(10)) u_dut16 (
    .i_clk(clk), .i_rst_n(rst_n), .i_lcd_wr(lcd_wr), .i_lcd_rs(lcd_rs),
    .i_lcd_cs_n(cs16_n), .i_lcd_rst_n(lcd_rst_n), .i_lcd_data(data),
    .o_command(cmd16), .o_command_valid(cv16), .o_param(par16),
    .o_param_idx(pidx16), .o_param_valid(pv16),
    .o_win_x0(wx0_16), .o_win_x1(wx1_16), .o_win_y0(wy0_16), .o_win_y1(wy1_16),
    .o_pix_rgb565(rgb16), .o_pix_x(px16), .o_pix_y(py16),
    .o_pix_valid(xv16), .o_frame_start(fs16)
  );

  lcd_bus_rx #(.DATA_W(8), .SYNC_STAGES(SYNC), .X_W(10), .Y_W(10)) u_dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_lcd_wr(lcd_wr), .i_lcd_rs(lcd_rs),
    .i_lcd_cs_n(cs8_n), .i_lcd_rst_n(lcd_rst_n), .i_lcd_data(data[7:0]),
    .o_command(cmd8), .o_command_valid(cv8), .o_param(par8),
    .o_param_idx(pidx8), .o_param_valid(pv8),
    .o_win_x0(wx0_8), .o_win_x1(wx1_8), .o_win_y0(wy0_8), .o_win_y1(wy1_8),
    .o_pix_rgb565(rgb8), .o_pix_x(px8), .o_pix_y(py8),
    .o_pix_valid(xv8), .o_frame_start(fs8)
  );

  // Capture every pulse so the checks see each event exactly once.
  always @(negedge clk) begin
    if (xv16) pq16.push_back('{rgb16, px16, py16, fs16});
    if (xv8)  pq8.push_back('{rgb8, px8, py8, fs8});
    if (pv16) aq16.push_back('{par16, pidx16});
    if (pv8)  aq8.push_back('{par8, pidx8});
    if (cv16) cq16.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic rs, input logic [15:0] d);
    lcd_rs = rs;
    data   = d;
    repeat (3) @(negedge clk);
    lcd_wr = 1'b1;
    t_wr   = cyc;
    repeat (4) @(negedge clk);
    lcd_wr = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic chk_pix(input bit w8, input string tag, input logic [15:0] rgb,
                         input logic [9:0] x, input logic [9:0] y, input logic fs);
    pix_t p;
    int   n;
    n = w8 ? pq8.size() : pq16.size();
    chk({tag, "_avail"}, 48'(n != 0), 48'd1);
    if (n != 0) begin
      p = w8 ? pq8.pop_front() : pq16.pop_front();
      chk(tag, 48'(p), 48'(pix_t'{rgb, x, y, fs}));
    end
  endtask

  initial begin
    par_t a;
    int   lat;

    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_cmd",   48'(cmd16),  48'h0);
    chk("rst_x1",    48'(wx1_16), 48'd1023);
    chk("rst_y1",    48'(wy1_16), 48'd1023);
    chk("rst_x0",    48'(wx0_16), 48'd0);
    chk("rst_pix",   48'({rgb16, px16, py16, xv16, fs16}), 48'h0);
    chk("rst_pidx",  48'({pidx16, par16, pv16, cv16}), 48'h0);

    // Window setup then a six-pixel burst across a 3x2 window.
    cs16_n = 1'b0;
    repeat (4) @(negedge clk);
    bus_wr(1'b0, 16'h002A);
    lat = (cq16.size() != 0) ? cq16[0] - t_wr : -1;
    chk("latency", 48'(lat), 48'(SYNC + 1));
    bus_wr(1'b1, 16'h0000); bus_wr(1'b1, 16'h0010);
    bus_wr(1'b1, 16'h0000); bus_wr(1'b1, 16'h0012);
    bus_wr(1'b0, 16'h002B);
    bus_wr(1'b1, 16'h0000); bus_wr(1'b1, 16'h0005);
    bus_wr(1'b1, 16'h0000); bus_wr(1'b1, 16'h0006);
    bus_wr(1'b0, 16'h002C);
    for (int i = 0; i < 6; i++) bus_wr(1'b1, 16'hA000 + 16'(i));
    chk("t1_win", 48'({wx0_16, wx1_16, wy0_16, wy1_16}), 48'({10'd16, 10'd18, 10'd5, 10'd6}));
    chk("t1_ncmd", 48'(cq16.size()), 48'd3);
    chk("t1_npar", 48'(aq16.size()), 48'd8);
    chk_pix(1'b0, "t1_p0", 16'hA000, 10'd16, 10'd5, 1'b1);
    chk_pix(1'b0, "t1_p1", 16'hA001, 10'd17, 10'd5, 1'b0);
    chk_pix(1'b0, "t1_p2", 16'hA002, 10'd18, 10'd5, 1'b0);
    chk_pix(1'b0, "t1_p3", 16'hA003, 10'd16, 10'd6, 1'b0);
    chk_pix(1'b0, "t1_p4", 16'hA004, 10'd17, 10'd6, 1'b0);
    chk_pix(1'b0, "t1_p5", 16'hA005, 10'd18, 10'd6, 1'b0);
    aq16.delete();

    // 3Ch resumes where the wrapped cursor left off.
    bus_wr(1'b0, 16'h003C);
    bus_wr(1'b1, 16'h1234);
    chk_pix(1'b0, "t4_p0", 16'h1234, 10'd16, 10'd5, 1'b0);

    // Unrelated command: index saturates, window untouched.
    bus_wr(1'b0, 16'h0036);
    for (int i = 0; i < 18; i++) bus_wr(1'b1, 16'h0040 + 16'(i));
    chk("t5_npar", 48'(aq16.size()), 48'd18);
    for (int i = 0; i < 18; i++) begin
      if (aq16.size() != 0) begin
        a = aq16.pop_front();
        chk($sformatf("t5_par%0d", i), 48'(a),
            48'(par_t'{8'h40 + 8'(i), (i > 15) ? 4'd15 : 4'(i)}));
      end
    end
    chk("t5_win", 48'({wx0_16, wx1_16, wy0_16, wy1_16}), 48'({10'd16, 10'd18, 10'd5, 10'd6}));
    chk("t5_nopix", 48'(pq16.size()), 48'd0);
    cs16_n = 1'b1;
    repeat (4) @(negedge clk);

    // 8-bit bus: two pixels from byte pairs.
    cs8_n = 1'b0;
    repeat (4) @(negedge clk);
    bus_wr(1'b0, 16'h002C);
    bus_wr(1'b1, 16'h00F8); bus_wr(1'b1, 16'h0000);
    bus_wr(1'b1, 16'h0007); bus_wr(1'b1, 16'h00E0);
    chk("t2_npar", 48'(aq8.size()), 48'd0);
    chk("t2_npix", 48'(pq8.size()), 48'd2);
    chk_pix(1'b1, "t2_p0", 16'hF800, 10'd0, 10'd0, 1'b1);
    chk_pix(1'b1, "t2_p1", 16'h07E0, 10'd1, 10'd0, 1'b0);

    // Deselect mid-pixel drops the pending high byte.
    bus_wr(1'b1, 16'h00F8);
    cs8_n = 1'b1;
    repeat (4) @(negedge clk);
    cs8_n = 1'b0;
    repeat (4) @(negedge clk);
    bus_wr(1'b1, 16'h0000); bus_wr(1'b1, 16'h001F);
    chk("t3_npix", 48'(pq8.size()), 48'd1);
    chk_pix(1'b1, "t3_p0", 16'h001F, 10'd2, 10'd0, 1'b0);

    // Reset pulse with a half pixel pending.
    bus_wr(1'b1, 16'h00AB);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t6_cmd",  48'({cmd16, cmd8}), 48'h0);
    chk("t6_win",  48'({wx0_16, wx1_16, wy0_16, wy1_16}), 48'({10'd0, 10'd1023, 10'd0, 10'd1023}));
    chk("t6_pix",  48'({rgb16, px16, py16, rgb8, px8, py8}), 48'h0);
    chk("t6_par",  48'({par16, pidx16, par8, pidx8}), 48'h0);
    chk("t6_x1_8", 48'(wx1_8), 48'd1023);
    repeat (4) @(negedge clk);
    chk("t6_nopix", 48'(pq8.size() + pq16.size()), 48'd0);
    bus_wr(1'b0, 16'h003C);
    bus_wr(1'b1, 16'h0012); bus_wr(1'b1, 16'h0034);
    chk_pix(1'b1, "t6_p8", 16'h1234, 10'd0, 10'd0, 1'b0);
    cs8_n  = 1'b1;
    cs16_n = 1'b0;
    repeat (4) @(negedge clk);
    bus_wr(1'b0, 16'h003C);
    bus_wr(1'b1, 16'h5555);
    chk_pix(1'b0, "t6_p16", 16'h5555, 10'd0, 10'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
